// File: rtl/fitness_pkg.sv
// rtl/fitness_pkg.sv - shared types and constants for the fitness-tracker datapath
package fitness_pkg;

  localparam int HR_W   = 8;
  localparam int STEP_W = 2;

  localparam logic [HR_W-1:0] HR_EMERGENCY = 8'd180;
  localparam logic [HR_W-1:0] HR_WARNING   = 8'd150;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_ALARM = 3'd3,
    ST_DONE  = 3'd4
  } session_state_t;

endpackage

// File: rtl/sat_run_counter.sv
// rtl/sat_run_counter.sv - saturating consecutive-event counter with threshold hit
module sat_run_counter #(
  parameter int W      = 8,
  parameter int THRESH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [W-1:0] THRESH_W  = W'(THRESH);
  localparam logic [W-1:0] THRESH_M1 = W'(THRESH - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // hit fires on the increment that reaches THRESH, so callers react on the same edge
  assign hit = inc & ~clr & (cnt_q >= THRESH_M1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < THRESH_W)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/workout_session_ctrl.sv
// rtl/workout_session_ctrl.sv - session sequencer: sample hold, 1 Hz forwarding, session FSM
module workout_session_ctrl
  import fitness_pkg::*;
#(
  parameter int EMERG_COUNT  = 3,
  parameter int IDLE_TIMEOUT = 30,
  parameter int MAX_SESSION  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic              start_btn,
  input  logic              stop_btn,
  input  logic              pause_btn,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [HR_W-1:0]   hr_in,
  input  logic [STEP_W-1:0] steps_in,
  output logic              calc_valid,
  output logic              calc_clr,
  output logic [HR_W-1:0]   hr_out,
  output logic [STEP_W-1:0] steps_out,
  output logic [2:0]        state,
  output logic              alarm,
  output logic [7:0]        session_sec,
  output logic [7:0]        missed_sec,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_RUN   = ST_RUN;
  localparam logic [2:0] S_PAUSE = ST_PAUSE;
  localparam logic [2:0] S_ALARM = ST_ALARM;
  localparam logic [2:0] S_DONE  = ST_DONE;
  localparam logic [7:0] MAX_M1  = 8'(MAX_SESSION - 1);

  logic [2:0]        state_q, state_d;
  logic              hold_full_q, hold_full_d;
  logic [HR_W-1:0]   hold_hr_q, hold_hr_d;
  logic [STEP_W-1:0] hold_steps_q, hold_steps_d;
  logic [7:0]        session_q, session_d;
  logic [7:0]        missed_q, missed_d;
  logic              calc_valid_q, calc_valid_d;
  logic [HR_W-1:0]   hr_out_q, hr_out_d;
  logic [STEP_W-1:0] steps_out_q, steps_out_d;
  logic              calc_clr_q, calc_clr_d;
  logic              done_q, done_d;

  logic run, accept, tick_run, fwd, miss, start_go, resume, clear_runs, max_hit;
  logic emerg_inc, emerg_clr, emerg_hit, idle_inc, idle_clr, idle_hit;

  assign run        = (state_q == S_RUN);
  assign accept     = sample_valid & run;
  assign tick_run   = tick_1hz & run;
  // the tick consumes the previous hold contents; a sample accepted now waits a second
  assign fwd        = tick_run & hold_full_q;
  assign miss       = tick_run & ~hold_full_q;
  assign start_go   = start_btn & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign resume     = pause_btn & ~stop_btn & (state_q == S_PAUSE);
  assign clear_runs = start_go | resume;
  assign max_hit    = tick_run & (session_q >= MAX_M1);

  assign emerg_inc = fwd & (hold_hr_q > HR_EMERGENCY);
  assign emerg_clr = (fwd & (hold_hr_q <= HR_EMERGENCY)) | clear_runs;
  assign idle_inc  = fwd & (hold_steps_q == '0);
  assign idle_clr  = (fwd & (hold_steps_q != '0)) | clear_runs;

  sat_run_counter #(.W(4), .THRESH(EMERG_COUNT)) u_emerg_cnt (
    .clk(clk), .rst(rst), .inc(emerg_inc), .clr(emerg_clr), .hit(emerg_hit)
  );

  sat_run_counter #(.W(8), .THRESH(IDLE_TIMEOUT)) u_idle_cnt (
    .clk(clk), .rst(rst), .inc(idle_inc), .clr(idle_clr), .hit(idle_hit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_btn) state_d = S_RUN;
      S_RUN: begin
        if (stop_btn)       state_d = S_DONE;
        else if (emerg_hit) state_d = S_ALARM;
        else if (max_hit)   state_d = S_DONE;
        else if (idle_hit)  state_d = S_PAUSE;
        else if (pause_btn) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (stop_btn)       state_d = S_DONE;
        else if (pause_btn) state_d = S_RUN;
      end
      S_ALARM: begin
        if (stop_btn)       state_d = S_DONE;
        else if (pause_btn) state_d = S_PAUSE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hold_full_d  = hold_full_q;
    hold_hr_d    = hold_hr_q;
    hold_steps_d = hold_steps_q;
    if (accept) begin
      hold_full_d  = 1'b1;
      hold_hr_d    = hr_in;
      hold_steps_d = steps_in;
    end else if (fwd) begin
      hold_full_d = 1'b0;
    end
    if (state_d != S_RUN) hold_full_d = 1'b0;

    session_d = session_q;
    missed_d  = missed_q;
    if (start_go) begin
      session_d = '0;
      missed_d  = '0;
    end else if (tick_run) begin
      session_d = session_q + 8'd1;
      if (miss && (missed_q != 8'hFF)) missed_d = missed_q + 8'd1;
    end

    calc_valid_d = fwd;
    hr_out_d     = fwd ? hold_hr_q : hr_out_q;
    steps_out_d  = fwd ? hold_steps_q : steps_out_q;
    calc_clr_d   = start_go;
    done_d       = (state_d == S_DONE) & (state_q != S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hold_full_q  <= 1'b0;
      hold_hr_q    <= '0;
      hold_steps_q <= '0;
      session_q    <= '0;
      missed_q     <= '0;
      calc_valid_q <= 1'b0;
      hr_out_q     <= '0;
      steps_out_q  <= '0;
      calc_clr_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_full_q  <= hold_full_d;
      hold_hr_q    <= hold_hr_d;
      hold_steps_q <= hold_steps_d;
      session_q    <= session_d;
      missed_q     <= missed_d;
      calc_valid_q <= calc_valid_d;
      hr_out_q     <= hr_out_d;
      steps_out_q  <= steps_out_d;
      calc_clr_q   <= calc_clr_d;
      done_q       <= done_d;
    end
  end

  assign sample_ready = run;
  assign calc_valid   = calc_valid_q;
  assign calc_clr     = calc_clr_q;
  assign hr_out       = hr_out_q;
  assign steps_out    = steps_out_q;
  assign state        = state_q;
  assign alarm        = (state_q == S_ALARM);
  assign session_sec  = session_q;
  assign missed_sec   = missed_q;
  assign done         = done_q;

endmodule

// File: tb/tb_workout_session_ctrl.sv
// tb/tb_workout_session_ctrl.sv - directed self-checking bench for workout_session_ctrl
module tb_workout_session_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0, start_btn = 1'b0, stop_btn = 1'b0, pause_btn = 1'b0;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic [7:0] hr_in = 8'd0;
  logic [1:0] steps_in = 2'd0;
  logic       calc_valid, calc_clr, alarm, done;
  logic [7:0] hr_out, session_sec, missed_sec;
  logic [1:0] steps_out;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  workout_session_ctrl #(.EMERG_COUNT(3), .IDLE_TIMEOUT(4), .MAX_SESSION(12)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .start_btn(start_btn),
    .stop_btn(stop_btn), .pause_btn(pause_btn), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .hr_in(hr_in), .steps_in(steps_in),
    .calc_valid(calc_valid), .calc_clr(calc_clr), .hr_out(hr_out),
    .steps_out(steps_out), .state(state), .alarm(alarm),
    .session_sec(session_sec), .missed_sec(missed_sec), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] hr, input logic [1:0] st);
    sample_valid = 1'b1; hr_in = hr; steps_in = st;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic restart();
    stop_btn = 1'b1; step(); stop_btn = 1'b0; step();
    start_btn = 1'b1; step(); start_btn = 1'b0; step();
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0; step();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if ({sample_ready, calc_valid, calc_clr, alarm, done} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {sample_ready, calc_valid, calc_clr, alarm, done}); end
    n_cmp++; if ({hr_out, steps_out, session_sec, missed_sec} !== 26'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {hr_out, steps_out, session_sec, missed_sec}); end
  endtask

  task automatic test_normal_run();
    start_btn = 1'b1; step(); start_btn = 1'b0;
    n_cmp++; if (state !== 3'd1 || calc_clr !== 1'b1) begin n_bad++; $display("FAIL start: got state %0d clr %b want 1 1", state, calc_clr); end
    step();
    n_cmp++; if (calc_clr !== 1'b0 || sample_ready !== 1'b1) begin n_bad++; $display("FAIL start_after: got clr %b ready %b want 0 1", calc_clr, sample_ready); end
    for (int i = 0; i < 5; i++) begin
      send(8'd100, 2'd2);
      tick();
      n_cmp++; if (calc_valid !== 1'b1 || hr_out !== 8'd100 || steps_out !== 2'd2) begin n_bad++; $display("FAIL fwd_%0d: got v %b hr %0d st %0d want 1 100 2", i, calc_valid, hr_out, steps_out); end
      step();
      n_cmp++; if (calc_valid !== 1'b0) begin n_bad++; $display("FAIL fwd_pulse_%0d: got %b want 0", i, calc_valid); end
    end
    n_cmp++; if (session_sec !== 8'd5 || missed_sec !== 8'd0) begin n_bad++; $display("FAIL normal_counts: got sess %0d miss %0d want 5 0", session_sec, missed_sec); end
  endtask

  task automatic test_alarm();
    restart();
    for (int i = 0; i < 3; i++) begin
      send(8'd190, 2'd2);
      tick();
      if (i < 2) begin
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL alarm_pre_%0d: got state %0d want 1", i, state); end
      end
    end
    n_cmp++; if (state !== 3'd3 || alarm !== 1'b1 || calc_valid !== 1'b1) begin n_bad++; $display("FAIL alarm_enter: got st %0d al %b v %b want 3 1 1", state, alarm, calc_valid); end
    pause_btn = 1'b1; step(); pause_btn = 1'b0;
    n_cmp++; if (state !== 3'd2 || alarm !== 1'b0) begin n_bad++; $display("FAIL alarm_ack: got st %0d al %b want 2 0", state, alarm); end
  endtask

  task automatic test_emerg_clear();
    logic [7:0] hrs [5];
    hrs[0] = 8'd185; hrs[1] = 8'd185; hrs[2] = 8'd170; hrs[3] = 8'd185; hrs[4] = 8'd185;
    restart();
    for (int i = 0; i < 5; i++) begin
      send(hrs[i], 2'd1);
      tick();
      n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL emerg_clear_%0d: got state %0d want 1", i, state); end
    end
    send(8'd185, 2'd1);
    tick();
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL emerg_third: got state %0d want 3", state); end
  endtask

  task automatic test_idle_timeout();
    restart();
    for (int i = 0; i < 4; i++) begin
      send(8'd80, 2'd0);
      tick();
      if (i < 3) begin
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL idle_pre_%0d: got state %0d want 1", i, state); end
      end
    end
    n_cmp++; if (state !== 3'd2 || calc_valid !== 1'b1 || session_sec !== 8'd4) begin n_bad++; $display("FAIL idle_pause: got st %0d v %b sess %0d want 2 1 4", state, calc_valid, session_sec); end
    pause_btn = 1'b1; step(); pause_btn = 1'b0;
    n_cmp++; if (state !== 3'd1 || session_sec !== 8'd4) begin n_bad++; $display("FAIL idle_resume: got st %0d sess %0d want 1 4", state, session_sec); end
    send(8'd80, 2'd0);
    tick();
    n_cmp++; if (state !== 3'd1 || session_sec !== 8'd5) begin n_bad++; $display("FAIL idle_cleared: got st %0d sess %0d want 1 5", state, session_sec); end
  endtask

  task automatic test_latest_wins();
    restart();
    send(8'd90, 2'd1);
    send(8'd110, 2'd3);
    tick();
    n_cmp++; if (calc_valid !== 1'b1 || hr_out !== 8'd110 || steps_out !== 2'd3) begin n_bad++; $display("FAIL latest: got v %b hr %0d st %0d want 1 110 3", calc_valid, hr_out, steps_out); end
    step();
    tick();
    n_cmp++; if (calc_valid !== 1'b0 || missed_sec !== 8'd1) begin n_bad++; $display("FAIL missed: got v %b miss %0d want 0 1", calc_valid, missed_sec); end
    sample_valid = 1'b1; hr_in = 8'd120; steps_in = 2'd1; tick_1hz = 1'b1;
    step();
    sample_valid = 1'b0; tick_1hz = 1'b0;
    n_cmp++; if (calc_valid !== 1'b0 || missed_sec !== 8'd2) begin n_bad++; $display("FAIL same_cycle: got v %b miss %0d want 0 2", calc_valid, missed_sec); end
    tick();
    n_cmp++; if (calc_valid !== 1'b1 || hr_out !== 8'd120) begin n_bad++; $display("FAIL same_cycle_next: got v %b hr %0d want 1 120", calc_valid, hr_out); end
  endtask

  task automatic test_max_session();
    restart();
    for (int i = 0; i < 11; i++) tick();
    n_cmp++; if (state !== 3'd1 || session_sec !== 8'd11) begin n_bad++; $display("FAIL max_pre: got st %0d sess %0d want 1 11", state, session_sec); end
    tick();
    n_cmp++; if (state !== 3'd4 || done !== 1'b1 || session_sec !== 8'd12 || missed_sec !== 8'd12) begin n_bad++; $display("FAIL max_done: got st %0d d %b sess %0d miss %0d want 4 1 12 12", state, done, session_sec, missed_sec); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL max_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_stop_and_reset();
    restart();
    send(8'd190, 2'd2); tick();
    send(8'd190, 2'd2); tick();
    send(8'd190, 2'd2);
    tick_1hz = 1'b1; stop_btn = 1'b1;
    step();
    tick_1hz = 1'b0; stop_btn = 1'b0;
    n_cmp++; if (state !== 3'd4 || done !== 1'b1 || alarm !== 1'b0 || calc_valid !== 1'b1) begin n_bad++; $display("FAIL stop_prio: got st %0d d %b al %b v %b want 4 1 0 1", state, done, alarm, calc_valid); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL stop_done_pulse: got %b want 0", done); end
    start_btn = 1'b1; step(); start_btn = 1'b0;
    n_cmp++; if (state !== 3'd1 || calc_clr !== 1'b1 || session_sec !== 8'd0) begin n_bad++; $display("FAIL restart: got st %0d clr %b sess %0d want 1 1 0", state, calc_clr, session_sec); end
    send(8'd140, 2'd3);
    tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (state !== 3'd0 || {sample_ready, calc_valid, calc_clr, alarm, done} !== 5'b0) begin n_bad++; $display("FAIL async_rst_flags: got st %0d flags %b want 0 00000", state, {sample_ready, calc_valid, calc_clr, alarm, done}); end
    n_cmp++; if ({hr_out, steps_out, session_sec, missed_sec} !== 26'd0) begin n_bad++; $display("FAIL async_rst_data: got %h want 0", {hr_out, steps_out, session_sec, missed_sec}); end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_alarm();
    test_emerg_clear();
    test_idle_timeout();
    test_latest_wins();
    test_max_session();
    test_stop_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
